bellek_asamasi: RTL

BELLEK_ASAMASI -- requirements
Module: bellek_asamasi

---
 rtl/bellek_asamasi_pkg.sv | 35 +++
 rtl/bellek_hizalayici.sv | 54 +++++
 rtl/bellek_asamasi.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bellek_asamasi_pkg.sv
// Shared types for the memory stage: FSM state, funct3 codes, writeback bundle.
package bellek_paket;

    typedef logic [0:0] durum_t;
    localparam durum_t BOSTA = 1'b0;
    localparam durum_t ISTEK = 1'b1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        oku;
        logic        yazmaca_yaz;
        logic [4:0]  hedef;
        logic [31:0] alu;
        logic        veri_hazir;
        logic [31:0] veri;
        logic        hizasiz;
        logic        zaman_asimi;
    } geri_yazma_t;

    // Unknown funct3 codes are folded into the misaligned path.
    function automatic logic hizasiz_mi(input logic [2:0] tip, input logic [1:0] konum);
        case (tip)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return konum[0];
            F3_W:        return (konum != 2'b00);
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/bellek_hizalayici.sv
// Combinational lane logic: store byte-enables/replication and load extraction with extension.
module bellek_hizalayici
    import bellek_paket::*;
(
    input  logic [2:0]  yaz_tipi,
    input  logic [1:0]  yaz_konum,
    input  logic [31:0] yaz_veri_ham,
    output logic [3:0]  maske,
    output logic [31:0] yaz_veri,
    input  logic [2:0]  oku_tipi,
    input  logic [1:0]  oku_konum,
    input  logic [31:0] oku_veri_ham,
    output logic [31:0] oku_veri
);

    logic [7:0]  bayt;
    logic [15:0] yarim;

    always_comb begin
        maske    = 4'b0000;
        yaz_veri = yaz_veri_ham;
        case (yaz_tipi)
            F3_B: begin
                maske    = 4'b0001 << yaz_konum;
                yaz_veri = {4{yaz_veri_ham[7:0]}};
            end
            F3_H: begin
                maske    = yaz_konum[1] ? 4'b1100 : 4'b0011;
                yaz_veri = {2{yaz_veri_ham[15:0]}};
            end
            F3_W:    maske = 4'b1111;
            default: maske = 4'b0000;
        endcase
    end

    always_comb begin
        bayt = oku_veri_ham[7:0];
        case (oku_konum)
            2'd1:    bayt = oku_veri_ham[15:8];
            2'd2:    bayt = oku_veri_ham[23:16];
            2'd3:    bayt = oku_veri_ham[31:24];
            default: bayt = oku_veri_ham[7:0];
        endcase
        yarim = oku_konum[1] ? oku_veri_ham[31:16] : oku_veri_ham[15:0];
        case (oku_tipi)
            F3_B:    oku_veri = {{24{bayt[7]}}, bayt};
            F3_BU:   oku_veri = {24'd0, bayt};
            F3_H:    oku_veri = {{16{yarim[15]}}, yarim};
            F3_HU:   oku_veri = {16'd0, yarim};
            default: oku_veri = oku_veri_ham;
        endcase
    end

endmodule

// File: rtl/bellek_asamasi.sv
// Memory stage: issues one data-memory request per aligned load/store, writeback one cycle after completion.
// Upstream stalls (durdur_o) while a request waits; a request is dropped after ZAMAN_ASIMI idle cycles.
module bellek_asamasi
    import bellek_paket::*;
#(
    parameter int ZAMAN_ASIMI = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        gecerli_i,
    input  logic        bellekten_oku_i,
    input  logic        bellege_yaz_i,
    input  logic [2:0]  buyruk_tipi_i,
    input  logic [31:0] adres_i,
    input  logic [31:0] yazilacak_veri_i,
    input  logic        yazmaca_yaz_i,
    input  logic [4:0]  hedef_yazmaci_i,
    input  logic [31:0] hedef_yazmac_verisi_i,
    output logic        durdur_o,
    output logic        bellek_istek_o,
    output logic        bellek_yaz_o,
    output logic [31:0] bellek_adres_o,
    output logic [31:0] bellek_yaz_veri_o,
    output logic [3:0]  bellek_maske_o,
    input  logic        bellek_hazir_i,
    input  logic [31:0] bellek_oku_veri_i,
    output logic        bellekten_oku_o,
    output logic        yazmaca_yaz_o,
    output logic [4:0]  hedef_yazmaci_o,
    output logic [31:0] hedef_yazmac_verisi_o,
    output logic        bellek_veri_hazir_o,
    output logic [31:0] bellek_veri_o,
    output logic        hizasiz_o,
    output logic        zaman_asimi_o
);

    localparam int SW = $clog2(ZAMAN_ASIMI + 1);

    durum_t      durum;
    logic [SW-1:0] sayac;
    logic        bellek_op, hatali, kabul, istek_al, asim, tam_v, yeni_v;

    logic        istek_oku, istek_yaz, istek_yy;
    logic [31:0] istek_adres, istek_veri, istek_alu;
    logic [3:0]  istek_maske;
    logic [2:0]  istek_tipi;
    logic [1:0]  istek_konum;
    logic [4:0]  istek_hedef;

    logic [3:0]  maske_c;
    logic [31:0] yaz_veri_c, yuklenen;

    geri_yazma_t tam_g, yeni_g, cikis_c, cikis_r, tut, tut_c;
    logic        tut_v, tut_v_c;

    assign durdur_o  = (durum == ISTEK) && !bellek_hazir_i;
    assign kabul     = gecerli_i && !durdur_o;
    assign bellek_op = bellekten_oku_i || bellege_yaz_i;
    assign hatali    = bellek_op && hizasiz_mi(buyruk_tipi_i, adres_i[1:0]);
    assign istek_al  = kabul && bellek_op && !hatali;
    assign asim      = (durum == ISTEK) && !bellek_hazir_i && (sayac == SW'(ZAMAN_ASIMI - 1));
    assign tam_v     = (durum == ISTEK) && (bellek_hazir_i || asim);
    assign yeni_v    = kabul && !istek_al;

    bellek_hizalayici u_hizalayici (
        .yaz_tipi     (buyruk_tipi_i),
        .yaz_konum    (adres_i[1:0]),
        .yaz_veri_ham (yazilacak_veri_i),
        .maske        (maske_c),
        .yaz_veri     (yaz_veri_c),
        .oku_tipi     (istek_tipi),
        .oku_konum    (istek_konum),
        .oku_veri_ham (bellek_oku_veri_i),
        .oku_veri     (yuklenen)
    );

    always_comb begin
        tam_g             = '0;
        tam_g.oku         = istek_oku && !asim;
        tam_g.yazmaca_yaz = istek_oku && istek_yy && !asim;
        tam_g.hedef       = istek_hedef;
        tam_g.alu         = istek_alu;
        tam_g.veri_hazir  = istek_oku && !asim;
        tam_g.veri        = (istek_oku && !asim) ? yuklenen : 32'd0;
        tam_g.zaman_asimi = asim;

        yeni_g             = '0;
        yeni_g.yazmaca_yaz = yazmaca_yaz_i && !hatali;
        yeni_g.hedef       = hedef_yazmaci_i;
        yeni_g.alu         = hedef_yazmac_verisi_i;
        yeni_g.hizasiz     = hatali;
    end

    // A completion and a freshly accepted non-memory instruction can both want the
    // same writeback slot; the younger one waits one cycle in the holdover register.
    always_comb begin
        cikis_c = '0;
        tut_c   = tut;
        tut_v_c = 1'b0;
        if (tut_v) begin
            cikis_c = tut;
            if (tam_v) begin
                tut_c   = tam_g;
                tut_v_c = 1'b1;
            end else if (yeni_v) begin
                tut_c   = yeni_g;
                tut_v_c = 1'b1;
            end
        end else if (tam_v) begin
            cikis_c = tam_g;
            if (yeni_v) begin
                tut_c   = yeni_g;
                tut_v_c = 1'b1;
            end
        end else if (yeni_v) begin
            cikis_c = yeni_g;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum       <= BOSTA;
            sayac       <= '0;
            istek_oku   <= 1'b0;
            istek_yaz   <= 1'b0;
            istek_yy    <= 1'b0;
            istek_adres <= '0;
            istek_veri  <= '0;
            istek_alu   <= '0;
            istek_maske <= '0;
            istek_tipi  <= '0;
            istek_konum <= '0;
            istek_hedef <= '0;
            cikis_r     <= '0;
            tut         <= '0;
            tut_v       <= 1'b0;
        end else begin
            cikis_r <= cikis_c;
            tut     <= tut_c;
            tut_v   <= tut_v_c;
            if (istek_al) begin
                durum       <= ISTEK;
                sayac       <= '0;
                istek_oku   <= bellekten_oku_i;
                istek_yaz   <= bellege_yaz_i;
                istek_yy    <= yazmaca_yaz_i;
                istek_adres <= {adres_i[31:2], 2'b00};
                istek_veri  <= yaz_veri_c;
                istek_alu   <= hedef_yazmac_verisi_i;
                istek_maske <= maske_c;
                istek_tipi  <= buyruk_tipi_i;
                istek_konum <= adres_i[1:0];
                istek_hedef <= hedef_yazmaci_i;
            end else if (tam_v) begin
                durum <= BOSTA;
            end else if (durum == ISTEK) begin
                sayac <= sayac + SW'(1);
            end
        end
    end

    assign bellek_istek_o    = (durum == ISTEK);
    assign bellek_yaz_o      = bellek_istek_o && istek_yaz;
    assign bellek_adres_o    = bellek_istek_o ? istek_adres : 32'd0;
    assign bellek_yaz_veri_o = bellek_istek_o ? istek_veri : 32'd0;
    assign bellek_maske_o    = bellek_istek_o ? istek_maske : 4'd0;

    assign bellekten_oku_o       = cikis_r.oku;
    assign yazmaca_yaz_o         = cikis_r.yazmaca_yaz;
    assign hedef_yazmaci_o       = cikis_r.hedef;
    assign hedef_yazmac_verisi_o = cikis_r.alu;
    assign bellek_veri_hazir_o   = cikis_r.veri_hazir;
    assign bellek_veri_o         = cikis_r.veri;
    assign hizasiz_o             = cikis_r.hizasiz;
    assign zaman_asimi_o         = cikis_r.zaman_asimi;

endmodule
